// File: rtl/div_step_stage.sv
// rtl/div_step_stage.sv - STEPS radix-2 restoring-divide iterations per stage, valid/ready handshake, flush on ld.
// Optional macro DIV_STEP_STAGE_SKID_EN adds a skid register so in_ready is a flop output.
module div_step_stage #(
    parameter int STEPS = 4,
    parameter int W     = 32
) (
    input  logic         aclk,
    input  logic         aresetn,
    input  logic         ld,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] rem_in,
    input  logic [W-1:0] quo_in,
    input  logic [W-1:0] den_in,
    input  logic         dz_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] rem_out,
    output logic [W-1:0] quo_out,
    output logic [W-1:0] den_out,
    output logic         dz_out
);

    typedef struct packed {
        logic [W-1:0] rem;
        logic [W-1:0] quo;
        logic [W-1:0] den;
        logic         dz;
    } word_t;

    word_t      new_word;
    logic [W:0] r;
    logic [W-1:0] q;

    always_comb begin
        r = {1'b0, rem_in};
        q = quo_in;
        for (int i = 0; i < STEPS; i++) begin
            r = {r[W-1:0], q[W-1]};
            q = {q[W-2:0], 1'b0};
            if (r >= {1'b0, den_in}) begin
                r    = r - {1'b0, den_in};
                q[0] = 1'b1;
            end
        end
        new_word.rem = r[W-1:0];
        new_word.quo = q;
        new_word.den = den_in;
        new_word.dz  = dz_in | (den_in == '0);
    end

    logic  rdy_q, rdy_d;
    logic  out_valid_q, out_valid_d;
    word_t out_word_q, out_word_d;
    logic  accept, drain;

    assign drain  = out_valid_q && out_ready;
    assign accept = in_valid && in_ready && !ld;

`ifdef DIV_STEP_STAGE_SKID_EN
    logic  skid_valid_q, skid_valid_d;
    word_t skid_word_q, skid_word_d;

    assign in_ready = rdy_q;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_word_d   = out_word_q;
        skid_valid_d = skid_valid_q;
        skid_word_d  = skid_word_q;
        if (ld) begin
            out_valid_d  = 1'b0;
            out_word_d   = '0;
            skid_valid_d = 1'b0;
            skid_word_d  = '0;
        end else if (!out_valid_q || drain) begin
            // Output slot frees up: the skid word is older than anything arriving now.
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_word_d   = skid_word_q;
                skid_valid_d = accept;
                skid_word_d  = accept ? new_word : '0;
            end else begin
                out_valid_d = accept;
                out_word_d  = accept ? new_word : '0;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_word_d  = new_word;
        end
        rdy_d = !skid_valid_d;
    end
`else
    assign in_ready = rdy_q && (out_ready || !out_valid_q);

    always_comb begin
        rdy_d       = 1'b1;
        out_valid_d = out_valid_q;
        out_word_d  = out_word_q;
        if (ld) begin
            out_valid_d = 1'b0;
            out_word_d  = '0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            out_word_d  = new_word;
        end else if (drain) begin
            out_valid_d = 1'b0;
            out_word_d  = '0;
        end
    end
`endif

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rdy_q        <= 1'b0;
            out_valid_q  <= 1'b0;
            out_word_q   <= '0;
`ifdef DIV_STEP_STAGE_SKID_EN
            skid_valid_q <= 1'b0;
            skid_word_q  <= '0;
`endif
        end else begin
            rdy_q        <= rdy_d;
            out_valid_q  <= out_valid_d;
            out_word_q   <= out_word_d;
`ifdef DIV_STEP_STAGE_SKID_EN
            skid_valid_q <= skid_valid_d;
            skid_word_q  <= skid_word_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign rem_out   = out_word_q.rem;
    assign quo_out   = out_word_q.quo;
    assign den_out   = out_word_q.den;
    assign dz_out    = out_word_q.dz;

endmodule

// File: tb/tb_div_step_stage.sv
// tb/tb_div_step_stage.sv - scoreboard bench for div_step_stage at STEPS=4 and STEPS=32.
module tb_div_step_stage;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        ld = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] rem_in = '0, quo_in = '0, den_in = '0;
    logic        dz_in = 1'b0;

    logic        in_ready4, out_valid4, dz_out4;
    logic [31:0] rem_out4, quo_out4, den_out4;
    logic        in_ready32, out_valid32, dz_out32;
    logic [31:0] rem_out32, quo_out32, den_out32;

    always #5 aclk = ~aclk;

    div_step_stage #(.STEPS(4), .W(32)) dut4 (
        .aclk(aclk), .aresetn(aresetn), .ld(ld), .in_valid(in_valid), .in_ready(in_ready4),
        .rem_in(rem_in), .quo_in(quo_in), .den_in(den_in), .dz_in(dz_in),
        .out_valid(out_valid4), .out_ready(out_ready), .rem_out(rem_out4), .quo_out(quo_out4),
        .den_out(den_out4), .dz_out(dz_out4)
    );

    div_step_stage #(.STEPS(32), .W(32)) dut32 (
        .aclk(aclk), .aresetn(aresetn), .ld(ld), .in_valid(in_valid), .in_ready(in_ready32),
        .rem_in(rem_in), .quo_in(quo_in), .den_in(den_in), .dz_in(dz_in),
        .out_valid(out_valid32), .out_ready(out_ready), .rem_out(rem_out32), .quo_out(quo_out32),
        .den_out(den_out32), .dz_out(dz_out32)
    );

    // Directed vectors: numerator, divisor, dz_in, hand-computed full-divide quotient/remainder.
    localparam int NV = 12;
    logic [31:0] v_num [NV] = '{32'hF0000000, 32'd100, 32'hFFFFFFFF, 32'h12345678, 32'h12345678, 32'h10,
                                 32'd1000, 32'd77, 32'hFFFFFFFF, 32'h80000000, 32'd12345, 32'hDEADBEEF};
    logic [31:0] v_den [NV] = '{32'd3, 32'd7, 32'h10000, 32'd0, 32'd5, 32'd2,
                                 32'd10, 32'd5, 32'd1, 32'h80000000, 32'd123, 32'h10};
    logic        v_dzi [NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [31:0] v_q32 [NV] = '{32'h50000000, 32'd14, 32'hFFFF, 32'hFFFFFFFF, 32'h03A4114B, 32'd8,
                                 32'd100, 32'd15, 32'hFFFFFFFF, 32'd1, 32'd100, 32'h0DEADBEE};
    logic [31:0] v_r32 [NV] = '{32'd0, 32'd2, 32'hFFFF, 32'h12345678, 32'd1, 32'd0,
                                 32'd0, 32'd2, 32'd0, 32'd0, 32'd45, 32'hF};

    typedef struct {
        logic [31:0] q4, r4, q32, r32, den;
        logic        dz;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   drop_at;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, got, want);
        end
    endtask

    // Four iterations from rem_in=0 only consume the top nibble of the numerator.
    function automatic exp_t make_exp(input int i);
        exp_t e;
        logic [31:0] t;
        t = v_num[i] >> 28;
        if (v_den[i] == 0) begin
            e.q4 = (v_num[i] << 4) | 32'hF;
            e.r4 = t;
        end else begin
            e.q4 = (v_num[i] << 4) | (t / v_den[i]);
            e.r4 = t % v_den[i];
        end
        e.q32 = v_q32[i];
        e.r32 = v_r32[i];
        e.den = v_den[i];
        e.dz  = v_dzi[i] | (v_den[i] == 0);
        return e;
    endfunction

    logic        prev_stall = 1'b0;
    logic [31:0] hq, hr, hd;
    logic        hz;

    initial begin
        forever begin
            @(negedge aclk);
            if (prev_stall && aresetn) begin
                check("stall_quo_hold", quo_out32, hq);
                check("stall_rem_hold", rem_out32, hr);
                check("stall_den_hold", den_out32, hd);
                check("stall_dz_hold", {31'd0, dz_out32}, {31'd0, hz});
            end
            if (out_valid32 && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("quo32", quo_out32, e.q32);
                    check("rem32", rem_out32, e.r32);
                    check("den32", den_out32, e.den);
                    check("dz32", {31'd0, dz_out32}, {31'd0, e.dz});
                    check("valid4", {31'd0, out_valid4}, 32'd1);
                    check("quo4", quo_out4, e.q4);
                    check("rem4", rem_out4, e.r4);
                    check("den4", den_out4, e.den);
                    check("dz4", {31'd0, dz_out4}, {31'd0, e.dz});
                end
            end
            prev_stall = out_valid32 && !out_ready && !ld && aresetn;
            hq = quo_out32; hr = rem_out32; hd = den_out32; hz = dz_out32;
        end
    end

    task automatic drive(input int first, input int n, input int stall, input int max_cyc, input bit drain);
        int idx;
        idx = first;
        drop_at = -1;
        for (int c = 0; c < max_cyc && idx < first + n; c++) begin
            out_ready = (c >= stall);
            in_valid  = 1'b1;
            rem_in    = '0;
            quo_in    = v_num[idx];
            den_in    = v_den[idx];
            dz_in     = v_dzi[idx];
            @(negedge aclk);
            if (!in_ready32 && drop_at < 0) drop_at = idx - first;
            if (in_ready32) begin
                exp_q.push_back(make_exp(idx));
                idx++;
            end
            @(posedge aclk);
            #1;
        end
        in_valid = 1'b0;
        if (drain) begin
            check("all_accepted", idx, first + n);
            out_ready = 1'b1;
            for (int c = 0; c < 50 && exp_q.size() != 0; c++) @(posedge aclk);
            #1;
            check("drain_timeout", exp_q.size(), 32'd0);
        end
    endtask

    initial begin
        #2;
        check("rst_out_valid", {31'd0, out_valid32}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready32}, 32'd0);
        check("rst_quo", quo_out32, 32'd0);
        check("rst_rem", rem_out32, 32'd0);
        repeat (2) @(posedge aclk);
        #3 aresetn = 1'b1;
        #1 check("in_ready_before_clk", {31'd0, in_ready32}, 32'd0);
        @(posedge aclk);
        #1 check("in_ready_after_clk", {31'd0, in_ready32}, 32'd1);

        drive(0, 6, 0, 30, 1'b1);

        drive(6, 5, 3, 40, 1'b1);
`ifdef DIV_STEP_STAGE_SKID_EN
        check("ready_drop_count", drop_at, 32'd2);
`else
        check("ready_drop_count", drop_at, 32'd1);
`endif

        drive(1, 2, 1000, 3, 1'b0);
        ld = 1'b1;
        @(posedge aclk);
        #1 ld = 1'b0;
        check("ld_out_valid", {31'd0, out_valid32}, 32'd0);
        check("ld_quo", quo_out32, 32'd0);
        check("ld_rem", rem_out32, 32'd0);
        check("ld_den", den_out32, 32'd0);
        exp_q.delete();
        drive(11, 1, 0, 20, 1'b1);

        drive(7, 2, 1000, 3, 1'b0);
        #1 aresetn = 1'b0;
        #1;
        check("arst_out_valid", {31'd0, out_valid32}, 32'd0);
        check("arst_quo", quo_out32, 32'd0);
        check("arst_in_ready", {31'd0, in_ready32}, 32'd0);
        exp_q.delete();
        repeat (2) @(posedge aclk);
        #3 aresetn = 1'b1;
        #1 check("arst_ready_before_clk", {31'd0, in_ready32}, 32'd0);
        @(posedge aclk);
        #1 check("arst_ready_after_clk", {31'd0, in_ready32}, 32'd1);
        check("arst_no_stale", {31'd0, out_valid32}, 32'd0);
        drive(10, 1, 0, 20, 1'b1);

        repeat (3) @(posedge aclk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/div_step_stage.md
Name: div_step_stage

Overview:
- One pipelined stage of the unsigned 32-bit restoring divider; performs STEPS radix-2 iterations on a (remainder, quotient-shift) pair.
- Sits directly upstream of the inter-stage pipeline register. Its rem_out/quo_out/den_out feed that register's s1/s2/b0 inputs. Its inputs come from the previous register's q1/q2/b0_out.
- Adds a valid/ready handshake so the divider chain can stall, plus a synchronous flush on ld.

Parameters:
- STEPS, 4, iterations performed per stage (1..32). STEPS=32 gives a complete divide in one stage.
- W, 32, operand width. Only 32 is verified.

Ports:
- aclk  in  1  clock, rising edge
- aresetn  in  1  asynchronous active-low reset
- ld  in  1  synchronous flush; drops all held data
- in_valid  in  1  upstream word valid
- in_ready  out  1  stage can accept a word this cycle
- rem_in  in  W  partial remainder (0 at chain head)
- quo_in  in  W  quotient-shift register (numerator at chain head)
- den_in  in  W  divisor
- dz_in  in  1  divide-by-zero flag from the previous stage
- out_valid  out  1  output word valid
- out_ready  in  1  downstream accepts
- rem_out  out  W  remainder after STEPS iterations
- quo_out  out  W  quotient-shift register after STEPS iterations
- den_out  out  W  divisor passed through unchanged
- dz_out  out  1  dz_in OR (den_in==0), registered with the word

Behaviour:
- Iteration, applied STEPS times combinationally with R = 33-bit zero-extended rem_in and Q = quo_in:
  - {R,Q} <<= 1.
  - If R >= {1'b0,den}: R -= den and Q[0] = 1; else Q[0] = 0.
- rem_out = R[W-1:0]. R[W] is always 0 after a step provided rem_in < den.
- den==0 is not special-cased. Every quotient bit becomes 1 and rem_out carries the shifted-in numerator bits.
- Transfer rules:
  - Input transfer happens when in_valid && in_ready.
  - Output transfer happens when out_valid && out_ready.
- Latency: 1 cycle from input transfer to out_valid when unstalled. Throughput is 1 word/cycle.
- Output holding: while out_valid && !out_ready, all out_* signals hold stable.
- Ordering: words leave in acceptance order. No word is dropped or duplicated except on ld or reset.
- Reset (aresetn low, asynchronous):
  - out_valid=0 and all data outputs 0.
  - in_ready=0 while reset is asserted, and in_ready=1 from the first clock after release.
  - Reset mid-stall discards held words.
- ld (synchronous, takes precedence over any transfer that cycle):
  - Next cycle out_valid=0 and data outputs 0.
  - Any in-flight or skid word is discarded.
  - No input is accepted in the ld cycle (in_ready is ignored).
- Simultaneous input and output transfer in the same cycle: the output register is replaced with the new word; there is no bubble.
- in_valid must not depend on in_ready. out_ready may depend on out_valid.

Optional Feature:
- Macro DIV_STEP_STAGE_SKID_EN.
- Defined:
  - 2-entry buffer (output register plus skid register).
  - in_ready is a register output: in_ready = !skid_full.
  - When the stage is stalled, one extra word is captured into skid.
  - When the output drains, skid moves to the output register; in_ready returns to 1 the cycle after skid empties.
- Undefined:
  - Single register.
  - in_ready = out_ready || !out_valid (combinational path from out_ready).

Test Plan:
- STEPS=4, single word rem_in=0, quo_in=0xF0000000, den_in=3, out_ready=1 -> 1 cycle later out_valid=1, quo_out=0x00000005, rem_out=0, den_out=3, dz_out=0.
- STEPS=32: 100/7 -> quo_out=14, rem_out=2. Also 0xFFFFFFFF/0x10000 -> quo_out=0xFFFF, rem_out=0xFFFF.
- STEPS=32, den_in=0, quo_in=0x12345678 -> quo_out=0xFFFFFFFF, rem_out=0x12345678, dz_out=1. A following word with den=5 has dz_out=0.
- Backpressure: stream 5 words while out_ready=0 for 3 cycles, then 1.
  - All 5 words emerge in order with stable data during the stall.
  - in_ready drops after 1 held word (no SKID) or after 2 (SKID_EN).
- ld asserted while a word is stalled with out_ready=0 -> next cycle out_valid=0 and outputs 0. The next accepted word emerges normally.
- aresetn pulsed low mid-stream, asynchronously between edges -> out_valid=0 immediately without waiting for an edge. in_ready=1 one clock after release. No stale word appears.
